// File: rtl/asip_pipe_pkg.sv
// Shared definitions for the ASIP vector pipeline boundary registers.
// Contents:
//   LANES_DEFAULT, DATA_SIZE_DEFAULT, REG_ADDR_DEFAULT - default configuration
//   ex_mem_payload_t - EX->MEM payload layout at the default configuration
//   ex_mem_payload_width() - payload width for any lane/data/address setting
// Field order, LSB first: result, neg, zero, rd, reg_we, mem_rd, mem_wr, set_flags.
package asip_pipe_pkg;

  localparam int LANES_DEFAULT     = 4;
  localparam int DATA_SIZE_DEFAULT = 8;
  localparam int REG_ADDR_DEFAULT  = 4;

  typedef struct packed {
    logic                                       set_flags;
    logic                                       mem_wr;
    logic                                       mem_rd;
    logic                                       reg_we;
    logic [REG_ADDR_DEFAULT-1:0]                rd;
    logic [LANES_DEFAULT-1:0]                   zero;
    logic [LANES_DEFAULT-1:0]                   neg;
    logic [LANES_DEFAULT*DATA_SIZE_DEFAULT-1:0] result;
  } ex_mem_payload_t;

  // Same layout as ex_mem_payload_t, sized for a parameterized instance.
  function automatic int ex_mem_payload_width(input int lanes, input int data_size,
                                              input int reg_addr_size);
    return lanes * data_size + 2 * lanes + reg_addr_size + 4;
  endfunction

endpackage

// File: rtl/pipe_skid_buffer.sv
// Generic 2-entry ready/valid skid buffer.
// The main entry drives the output; the skid entry absorbs the one transfer
// that arrives while main is stalled, so in_ready_o can be a pure register.
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   flush_i       - synchronous drop of both entries; input ignored this cycle
//   in_valid_i    - upstream offers in_data_i
//   in_ready_o    - registered, high while the skid entry is empty
//   in_data_i     - upstream payload
//   out_valid_o   - main entry valid
//   out_ready_i   - downstream accepts
//   out_data_o    - main entry payload
module pipe_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] main_data_q,  main_data_d;
  logic [WIDTH-1:0] skid_data_q,  skid_data_d;
  logic             in_xfer, out_xfer;

  assign in_ready_o  = !skid_valid_q;
  assign out_valid_o = main_valid_q;
  assign out_data_o  = main_data_q;

  assign in_xfer  = in_valid_i && !skid_valid_q && !flush_i;
  assign out_xfer = main_valid_q && out_ready_i;

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_data_d  = main_data_q;
    skid_data_d  = skid_data_q;
    if (out_xfer && skid_valid_q) begin
      // Skid drains into main; no input can arrive because in_ready_o is low.
      main_valid_d = 1'b1;
      skid_valid_d = 1'b0;
      main_data_d  = skid_data_q;
    end else if (in_xfer && (!main_valid_q || out_xfer)) begin
      // Main empty or draining this edge: new entry goes straight to main.
      main_valid_d = 1'b1;
      main_data_d  = in_data_i;
    end else if (in_xfer) begin
      // Main stalled: park the new entry in skid.
      skid_valid_d = 1'b1;
      skid_data_d  = in_data_i;
    end else if (out_xfer) begin
      main_valid_d = 1'b0;
    end
    // Payload may keep stale data; only the valids need clearing.
    if (flush_i) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_data_q  <= main_data_d;
      skid_data_q  <= skid_data_d;
    end
  end

endmodule

// File: rtl/ex_mem_skid_reg.sv
// EX->MEM pipeline boundary register for the vector ASIP.
// Buffers per-lane ALU results, flags and control through a 2-entry skid
// buffer, and owns the architectural condition-flag register.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   flush               - squash all buffered entries at the next edge
//   ex_valid/ex_ready   - execute-side handshake (ex_ready registered)
//   ex_result           - lane i at [i*dataSize +: dataSize]
//   ex_neg, ex_zero     - per-lane ALU flags
//   ex_rd, ex_reg_we, ex_mem_rd, ex_mem_wr, ex_set_flags - control payload
//   mem_valid/mem_ready - memory-side handshake
//   mem_result, mem_rd, mem_reg_we, mem_mem_rd, mem_mem_wr - head entry payload
//   flag_neg, flag_zero - architectural flags for branch logic
module ex_mem_skid_reg
  import asip_pipe_pkg::*;
#(
  parameter int dataSize    = DATA_SIZE_DEFAULT,
  parameter int lanes       = LANES_DEFAULT,
  parameter int regAddrSize = REG_ADDR_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      ex_valid,
  output logic                      ex_ready,
  input  logic [lanes*dataSize-1:0] ex_result,
  input  logic [lanes-1:0]          ex_neg,
  input  logic [lanes-1:0]          ex_zero,
  input  logic [regAddrSize-1:0]    ex_rd,
  input  logic                      ex_reg_we,
  input  logic                      ex_mem_rd,
  input  logic                      ex_mem_wr,
  input  logic                      ex_set_flags,
  output logic                      mem_valid,
  input  logic                      mem_ready,
  output logic [lanes*dataSize-1:0] mem_result,
  output logic [regAddrSize-1:0]    mem_rd,
  output logic                      mem_reg_we,
  output logic                      mem_mem_rd,
  output logic                      mem_mem_wr,
  output logic [lanes-1:0]          flag_neg,
  output logic [lanes-1:0]          flag_zero
);

  localparam int PW       = ex_mem_payload_width(lanes, dataSize, regAddrSize);
  localparam int RES_W    = lanes * dataSize;
  localparam int NEG_LSB  = RES_W;
  localparam int ZERO_LSB = NEG_LSB + lanes;
  localparam int RD_LSB   = ZERO_LSB + lanes;
  localparam int WE_BIT   = RD_LSB + regAddrSize;
  localparam int MRD_BIT  = WE_BIT + 1;
  localparam int MWR_BIT  = WE_BIT + 2;
  localparam int SF_BIT   = WE_BIT + 3;

  logic [PW-1:0]    in_pl, head_pl;
  logic [lanes-1:0] flag_neg_q,  flag_neg_d;
  logic [lanes-1:0] flag_zero_q, flag_zero_d;
  logic             out_xfer;

  assign in_pl = {ex_set_flags, ex_mem_wr, ex_mem_rd, ex_reg_we, ex_rd,
                  ex_zero, ex_neg, ex_result};

  pipe_skid_buffer #(
    .WIDTH(PW)
  ) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (flush),
    .in_valid_i (ex_valid),
    .in_ready_o (ex_ready),
    .in_data_i  (in_pl),
    .out_valid_o(mem_valid),
    .out_ready_i(mem_ready),
    .out_data_o (head_pl)
  );

  assign mem_result = head_pl[RES_W-1:0];
  assign mem_rd     = head_pl[RD_LSB +: regAddrSize];
  assign mem_reg_we = head_pl[WE_BIT];
  assign mem_mem_rd = head_pl[MRD_BIT];
  assign mem_mem_wr = head_pl[MWR_BIT];

  // Not gated by flush: the memory stage has already consumed this entry.
  assign out_xfer = mem_valid && mem_ready;

  always_comb begin
    flag_neg_d  = flag_neg_q;
    flag_zero_d = flag_zero_q;
    if (out_xfer && head_pl[SF_BIT]) begin
      flag_neg_d  = head_pl[NEG_LSB +: lanes];
      flag_zero_d = head_pl[ZERO_LSB +: lanes];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_neg_q  <= '0;
      flag_zero_q <= '0;
    end else begin
      flag_neg_q  <= flag_neg_d;
      flag_zero_q <= flag_zero_d;
    end
  end

  assign flag_neg  = flag_neg_q;
  assign flag_zero = flag_zero_q;

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
module tb_ex_mem_skid_reg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic [31:0] ex_result = '0;
  logic [3:0]  ex_neg = '0;
  logic [3:0]  ex_zero = '0;
  logic [3:0]  ex_rd = '0;
  logic        ex_reg_we = 1'b0;
  logic        ex_mem_rd = 1'b0;
  logic        ex_mem_wr = 1'b0;
  logic        ex_set_flags = 1'b0;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_result;
  logic [3:0]  mem_rd;
  logic        mem_reg_we, mem_mem_rd, mem_mem_wr;
  logic [3:0]  flag_neg, flag_zero;

  int checks = 0;
  int errors = 0;

  ex_mem_skid_reg dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_result(ex_result),
    .ex_neg(ex_neg), .ex_zero(ex_zero), .ex_rd(ex_rd), .ex_reg_we(ex_reg_we),
    .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr), .ex_set_flags(ex_set_flags),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_result(mem_result),
    .mem_rd(mem_rd), .mem_reg_we(mem_reg_we), .mem_mem_rd(mem_mem_rd),
    .mem_mem_wr(mem_mem_wr), .flag_neg(flag_neg), .flag_zero(flag_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of held entries (at most two) and the flag pair.
  typedef struct {
    logic [31:0] res;
    logic [3:0]  neg, zero, rd;
    logic        we, mrd, mwr, sf;
  } ent_t;

  ent_t       mq[$];
  logic [3:0] m_fneg, m_fzero;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_fneg  = '0;
      m_fzero = '0;
    end else begin
      bit   can_take, give;
      ent_t e;
      can_take = ex_valid && (mq.size() < 2) && !flush;
      give     = (mq.size() > 0) && mem_ready;
      if (give) begin
        e = mq.pop_front();
        if (e.sf) begin
          m_fneg  = e.neg;
          m_fzero = e.zero;
        end
      end
      if (flush) mq.delete();
      else if (can_take) begin
        e.res = ex_result; e.neg = ex_neg; e.zero = ex_zero; e.rd = ex_rd;
        e.we = ex_reg_we; e.mrd = ex_mem_rd; e.mwr = ex_mem_wr; e.sf = ex_set_flags;
        mq.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    chk("mdl_mem_valid", 64'(mem_valid), 64'(mq.size() > 0));
    chk("mdl_ex_ready", 64'(ex_ready), 64'(mq.size() < 2));
    chk("mdl_flag_neg", 64'(flag_neg), 64'(m_fneg));
    chk("mdl_flag_zero", 64'(flag_zero), 64'(m_fzero));
    if (mq.size() > 0) begin
      chk("mdl_mem_result", 64'(mem_result), 64'(mq[0].res));
      chk("mdl_mem_ctrl", 64'({mem_rd, mem_reg_we, mem_mem_rd, mem_mem_wr}),
          64'({mq[0].rd, mq[0].we, mq[0].mrd, mq[0].mwr}));
    end
  end

  task automatic drive(input logic v, input logic [31:0] r, input logic [3:0] n,
                       input logic [3:0] z, input logic [3:0] rd, input logic sf);
    ex_valid = v; ex_result = r; ex_neg = n; ex_zero = z; ex_rd = rd;
    ex_reg_we = rd[0]; ex_mem_rd = rd[1]; ex_mem_wr = rd[2]; ex_set_flags = sf;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    chk("rst_mem_valid", 64'(mem_valid), 64'd0);
    chk("rst_ex_ready", 64'(ex_ready), 64'd1);
    chk("rst_flags", 64'({flag_neg, flag_zero}), 64'd0);
    chk("rst_payload", 64'({mem_result, mem_rd, mem_reg_we, mem_mem_rd, mem_mem_wr}), 64'd0);
    step();
    rst_n = 1'b1;

    // Streaming
    mem_ready = 1'b1;
    drive(1, 32'h04030201, 4'h0, 4'h0, 4'h3, 0);
    step();
    chk("stream_a", 64'(mem_result), 64'h04030201);
    chk("stream_a_rd", 64'(mem_rd), 64'h3);
    chk("stream_rdy_a", 64'(ex_ready), 64'd1);
    drive(1, 32'h08070605, 4'h0, 4'h0, 4'h5, 0);
    step();
    chk("stream_b", 64'(mem_result), 64'h08070605);
    chk("stream_rdy_b", 64'(ex_ready), 64'd1);
    drive(0, 32'h0, 4'h0, 4'h0, 4'h0, 0);
    step();
    chk("stream_empty", 64'(mem_valid), 64'd0);

    // Backpressure
    mem_ready = 1'b0;
    drive(1, 32'h11111111, 4'h0, 4'h0, 4'h1, 0);
    step();
    chk("bp_rdy_after_a", 64'(ex_ready), 64'd1);
    drive(1, 32'h22222222, 4'h0, 4'h0, 4'h2, 0);
    step();
    chk("bp_rdy_after_b", 64'(ex_ready), 64'd0);
    chk("bp_head_a", 64'(mem_result), 64'h11111111);
    drive(1, 32'h33333333, 4'h0, 4'h0, 4'h4, 0);
    step();
    chk("bp_hold_a", 64'(mem_result), 64'h11111111);
    drive(0, 32'h0, 4'h0, 4'h0, 4'h0, 0);
    mem_ready = 1'b1;
    step();
    chk("bp_head_b", 64'(mem_result), 64'h22222222);
    chk("bp_rdy_drained", 64'(ex_ready), 64'd1);
    step();
    chk("bp_done", 64'(mem_valid), 64'd0);

    // Flags
    drive(1, 32'hAAAA0001, 4'b0101, 4'b0010, 4'h6, 1);
    step();
    drive(1, 32'hAAAA0002, 4'b1010, 4'b1111, 4'h7, 0);
    step();
    chk("flag_neg_set", 64'(flag_neg), 64'b0101);
    chk("flag_zero_set", 64'(flag_zero), 64'b0010);
    drive(0, 32'h0, 4'h0, 4'h0, 4'h0, 0);
    step();
    chk("flag_neg_keep", 64'(flag_neg), 64'b0101);
    chk("flag_zero_keep", 64'(flag_zero), 64'b0010);

    // Flush with two entries buffered and a third offered
    mem_ready = 1'b0;
    drive(1, 32'h55555555, 4'h0, 4'h0, 4'h1, 0);
    step();
    drive(1, 32'h66666666, 4'h0, 4'h0, 4'h2, 0);
    step();
    drive(1, 32'h77777777, 4'h0, 4'h0, 4'h3, 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(0, 32'h0, 4'h0, 4'h0, 4'h0, 0);
    chk("flush_valid", 64'(mem_valid), 64'd0);
    chk("flush_ready", 64'(ex_ready), 64'd1);
    step();
    chk("flush_not_captured", 64'(mem_valid), 64'd0);

    // Flush coincident with an out_xfer carrying set_flags
    drive(1, 32'h88888888, 4'b0001, 4'b1000, 4'h5, 1);
    step();
    drive(0, 32'h0, 4'h0, 4'h0, 4'h0, 0);
    mem_ready = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flushx_zero", 64'(flag_zero), 64'b1000);
    chk("flushx_neg", 64'(flag_neg), 64'b0001);
    chk("flushx_empty", 64'(mem_valid), 64'd0);

    // Asynchronous reset with two entries held
    mem_ready = 1'b0;
    drive(1, 32'h99999999, 4'hF, 4'hF, 4'h1, 1);
    step();
    drive(1, 32'hBBBBBBBB, 4'hF, 4'hF, 4'h2, 1);
    step();
    chk("ar_full", 64'(ex_ready), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 64'(mem_valid), 64'd0);
    chk("ar_ready", 64'(ex_ready), 64'd1);
    chk("ar_flags", 64'({flag_neg, flag_zero}), 64'd0);
    step();
    rst_n = 1'b1;

    // Mixed traffic
    for (int i = 0; i < 32; i++) begin
      logic [7:0] b;
      b = 8'(i * 37 + 11);
      drive((i % 3) != 2, {b, ~b, b ^ 8'h5A, 8'(i)}, 4'(i), 4'(~i), 4'(i * 5),
            i[0]);
      mem_ready = ((i % 4) != 1) && ((i % 7) != 3);
      flush = (i == 19);
      step();
    end
    flush = 1'b0;
    drive(0, 32'h0, 4'h0, 4'h0, 4'h0, 0);
    mem_ready = 1'b1;
    step();
    step();
    chk("final_empty", 64'(mem_valid), 64'd0);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_mem_skid_reg.md
Name: ex_mem_skid_reg

Overview:
- Pipeline boundary register between the vector execute stage (per-lane ALUs) and the memory stage.
- Captures per-lane ALU results, per-lane neg/zero flags and control payload using a ready/valid handshake.
- Holds a 2-entry skid buffer so a registered ex_ready still sustains one transfer per cycle.
- Owns the architectural condition-flag register consumed by branch logic.

Parameters:
- dataSize, 8, width of one lane result (matches the ALU lane width)
- lanes, 4, number of vector lanes
- regAddrSize, 4, destination register address width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous squash of all buffered entries
- ex_valid  in  1  execute stage presents an entry
- ex_ready  out  1  this block can accept; registered, = !skid_valid
- ex_result  in  lanes*dataSize  lane i at bits [i*dataSize +: dataSize]
- ex_neg  in  lanes  per-lane ALU neg_flag
- ex_zero  in  lanes  per-lane ALU zero_flag
- ex_rd  in  regAddrSize  destination register
- ex_reg_we  in  1  register write enable
- ex_mem_rd  in  1  memory read
- ex_mem_wr  in  1  memory write
- ex_set_flags  in  1  entry updates the flag register
- mem_valid  out  1  output entry valid
- mem_ready  in  1  memory stage accepts
- mem_result, mem_rd, mem_reg_we, mem_mem_rd, mem_mem_wr  out  as inputs  payload of the head entry
- flag_neg  out  lanes  architectural negative flags
- flag_zero  out  lanes  architectural zero flags

Behaviour:
- Reset (rst_n low, async): main_valid=0, skid_valid=0, ex_ready=1, mem_valid=0, all payload outputs 0, flag_neg=0, flag_zero=0.
- Storage: main entry drives the mem_* outputs directly; the skid entry is the overflow entry.
- Transfer definitions:
  - in_xfer = ex_valid & ex_ready & !flush
  - out_xfer = mem_valid & mem_ready
- Latency: an entry accepted at cycle N is on mem_* at N+1 when main is empty or draining.
- Update rules at each edge, with flush low:
  - out_xfer and skid_valid: skid moves to main; an in_xfer is impossible because ex_ready=0.
  - out_xfer, no skid, in_xfer: the new entry loads main.
  - out_xfer, no skid, no in_xfer: main_valid becomes 0.
  - no out_xfer, in_xfer, main empty: the new entry loads main.
  - no out_xfer, in_xfer, main full: the new entry loads skid, and ex_ready goes 0 next cycle.
- The valid entry count is at most 2. The payload of a held entry never changes while mem_valid=1 and mem_ready=0.
- Flags:
  - On out_xfer of an entry with set_flags=1, flag_neg and flag_zero load that entry's ex_neg and ex_zero, visible the next cycle.
  - An entry with set_flags=0 leaves the flags unchanged.
- Flush:
  - At the next edge, main_valid=0 and skid_valid=0.
  - The payload registers need not clear.
  - ex_ready=1 the following cycle.
  - The input is ignored in the flush cycle.
  - An out_xfer in the flush cycle is still a completed transfer: its flag update is applied, because the memory stage already observed it.
- Simultaneous events: flush takes priority over in_xfer. out_xfer plus in_xfer with a full main and an empty skid passes through with no bubble.
- Reset mid-operation: all entries are dropped immediately, asynchronously, and the flags clear.
- Widths: all payloads are copied bit-exact. No arithmetic is performed here.

Decomposition:
- Shared package asip_pipe_pkg holds:
  - typedef ex_mem_payload_t, a packed struct of result, neg, zero, rd, reg_we, mem_rd, mem_wr, set_flags
  - constants LANES_DEFAULT and DATA_SIZE_DEFAULT
- One sub-module, pipe_skid_buffer:
  - generic 2-entry ready/valid buffer over a parameterized payload width
  - contains the main/skid logic
- The top level instantiates pipe_skid_buffer and adds the flag register and the flush/flag rules.

Test Plan:
- Reset with entries held (ex_valid=1, mem_ready=0, 2 entries buffered), then pulse rst_n low mid-cycle -> mem_valid=0, ex_ready=1 and flags=0 immediately, without waiting for a clock edge.
- Streaming: mem_ready=1, ex_result=0x04030201 then 0x08070605 on back-to-back cycles -> mem_result shows 0x04030201 then 0x08070605 one cycle later each, with ex_ready constantly 1.
- Backpressure: mem_ready=0, push A=0x11111111 then B=0x22222222 -> ex_ready=0 after B. Then mem_ready=1 -> A, then B, each delivered exactly once, and ex_ready=1 again after the skid drains.
- Flags: entry ex_neg=4'b0101, ex_zero=4'b0010, set_flags=1 transferred -> flag_neg=0101 and flag_zero=0010 next cycle. A following entry with set_flags=0 and ex_zero=4'b1111 -> flags unchanged.
- Flush with 2 buffered entries and ex_valid=1 -> next cycle mem_valid=0 and ex_ready=1, and the offered entry is not captured.
- Flush coincident with out_xfer of a set_flags=1 entry carrying ex_zero=4'b1000 -> flag_zero=1000 and buffer empty next cycle.
